// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings (common with the receive side),
// frame bit polarities, TX state encoding and parity helpers.
package uart_pkg;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned IDX_W  = 3;

   localparam logic [1:0] PAR_NONE00 = 2'b00;
   localparam logic [1:0] PAR_ODD    = 2'b01;
   localparam logic [1:0] PAR_EVEN   = 2'b10;
   localparam logic [1:0] PAR_NONE11 = 2'b11;

   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_PARITY,
      TX_STOP
   } tx_state_e;

   // Both 00 and 11 mean "no parity slot in the frame".
   function automatic logic has_parity(input logic [1:0] ptype);
      return !((ptype == PAR_NONE00) || (ptype == PAR_NONE11));
   endfunction

   // ODD: total ones including parity is odd; EVEN: total is even.
   function automatic logic parity_bit(input logic [DATA_W-1:0] data,
                                       input logic [1:0]        ptype);
      return (ptype == PAR_ODD) ? ~^data : ^data;
   endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// Byte handshake and serial-line bundle for the UART transmitter.
//   send/data_in/parity_type : producer -> transmitter
//   tx/busy/done             : transmitter -> consumer
interface uart_tx_frame_if;
   import uart_pkg::*;

   logic              send;
   logic [DATA_W-1:0] data_in;
   logic [1:0]        parity_type;
   logic              tx;
   logic              busy;
   logic              done;

   modport master (
      output send, data_in, parity_type,
      input  tx, busy, done
   );

   modport slave (
      input  send, data_in, parity_type,
      output tx, busy, done
   );

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and wraps at each bit boundary.
//   clk, reset       : clock, async active-high reset
//   clear            : synchronous clear, holds the count at 0
//   bit_tick         : registered, high during the last cycle of each bit
//   bit_tick_next_c  : combinational, bit_tick value for the next cycle
module uart_baud_gen #(
   parameter int unsigned CLKS_PER_BIT = 868
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic bit_tick,
   output logic bit_tick_next_c
);

   localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_next;
   logic             r_tick;

   // Next count: clear wins, otherwise wrap at the bit boundary.
   always_comb begin
      w_cnt_next = r_cnt + CNT_W'(1);
      if (clear) begin
         w_cnt_next = '0;
      end else if (r_cnt == CNT_LAST) begin
         w_cnt_next = '0;
      end
   end

   assign bit_tick_next_c = (w_cnt_next == CNT_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt  <= '0;
         r_tick <= 1'b0;
      end else begin
         r_cnt  <= w_cnt_next;
         r_tick <= bit_tick_next_c;
      end
   end

   assign bit_tick = r_tick;

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start bit, 8 data bits LSB first, optional parity,
// one stop bit, shifted out at CLKS_PER_BIT clocks per bit.
//   clk, reset : clock, async active-high reset
//   bus        : slave side of uart_tx_frame_if (send/data_in/parity_type in;
//                tx/busy/done out, all registered)
module uart_tx_frame
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 868
) (
   input  logic          clk,
   input  logic          reset,
   uart_tx_frame_if.slave bus
);

   tx_state_e         r_state, w_state_next;
   logic [DATA_W-1:0] r_data,  w_data_next;
   logic [1:0]        r_ptype, w_ptype_next;
   logic              r_par,   w_par_next;
   logic [IDX_W-1:0]  r_idx,   w_idx_next;
   logic              r_tx,    w_tx_next;
   logic              r_busy,  w_busy_next;
   logic              r_done,  w_done_next;
   logic              w_clear;
   logic              w_tick;
   logic              w_tick_next;

   // Timer is held at 0 while idle so the start bit gets a full period.
   assign w_clear = (r_state == TX_IDLE);

   uart_baud_gen #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud (
      .clk             (clk),
      .reset           (reset),
      .clear           (w_clear),
      .bit_tick        (w_tick),
      .bit_tick_next_c (w_tick_next)
   );

   // Next-state and next-output logic; outputs are computed one cycle ahead.
   always_comb begin
      w_state_next = r_state;
      w_data_next  = r_data;
      w_ptype_next = r_ptype;
      w_par_next   = r_par;
      w_idx_next   = r_idx;
      w_tx_next    = r_tx;
      w_busy_next  = r_busy;
      w_done_next  = 1'b0;

      case (r_state)
         TX_IDLE: begin
            w_tx_next   = STOP_BIT;
            w_busy_next = 1'b0;
            if (bus.send) begin
               w_data_next  = bus.data_in;
               w_ptype_next = bus.parity_type;
               w_par_next   = parity_bit(bus.data_in, bus.parity_type);
               w_idx_next   = '0;
               w_state_next = TX_START;
               w_tx_next    = START_BIT;
               w_busy_next  = 1'b1;
            end
         end
         TX_START: begin
            if (w_tick) begin
               w_state_next = TX_DATA;
               w_idx_next   = '0;
               w_tx_next    = r_data[0];
            end
         end
         TX_DATA: begin
            if (w_tick) begin
               if (r_idx == IDX_W'(DATA_W - 1)) begin
                  if (has_parity(r_ptype)) begin
                     w_state_next = TX_PARITY;
                     w_tx_next    = r_par;
                  end else begin
                     w_state_next = TX_STOP;
                     w_tx_next    = STOP_BIT;
                  end
               end else begin
                  w_idx_next = r_idx + IDX_W'(1);
                  w_tx_next  = r_data[r_idx + IDX_W'(1)];
               end
            end
         end
         TX_PARITY: begin
            if (w_tick) begin
               w_state_next = TX_STOP;
               w_tx_next    = STOP_BIT;
            end
         end
         TX_STOP: begin
            // done must be registered into the final stop cycle.
            w_done_next = w_tick_next;
            if (w_tick) begin
               w_state_next = TX_IDLE;
               w_busy_next  = 1'b0;
               w_tx_next    = STOP_BIT;
            end
         end
         default: begin
            w_state_next = TX_IDLE;
            w_tx_next    = STOP_BIT;
            w_busy_next  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= TX_IDLE;
         r_data  <= '0;
         r_ptype <= PAR_NONE00;
         r_par   <= 1'b0;
         r_idx   <= '0;
         r_tx    <= STOP_BIT;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_data  <= w_data_next;
         r_ptype <= w_ptype_next;
         r_par   <= w_par_next;
         r_idx   <= w_idx_next;
         r_tx    <= w_tx_next;
         r_busy  <= w_busy_next;
         r_done  <= w_done_next;
      end
   end

   assign bus.tx   = r_tx;
   assign bus.busy = r_busy;
   assign bus.done = r_done;

endmodule
